// File: rtl/uart_dump_ctrl.sv
// -----------------------------------------------------------------------------
// uart_dump_ctrl
//
// Sequencer behind the monitor's r (data memory dump), p (instruction memory
// dump) and j (PC print) commands. It latches start/end word addresses from
// the command decoder and issues one word read at a time. Each word is printed
// as eight lowercase hex characters. In dump mode every word is followed by a
// space, and a line is closed with CR LF after WORDS_PER_LINE words or after
// the last word. A PC print is "xxxxxxxx" CR LF.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   uart_data_i           byte address / value assembled by the command decoder
//   read_start_set_i      latch data-memory start address
//   read_end_set_i        latch data-memory end address and start the dump
//   read_stop_i           abort a data-memory dump
//   pgm_start_set_i       latch instruction-memory start address
//   pgm_end_set_i         latch instruction-memory end address and start the dump
//   pgm_stop_i            abort an instruction-memory dump
//   pc_print_i            print pc_value_i (sampled with this pulse)
//   pc_value_i            current CPU PC
//   mem_re_o              one-cycle word read request
//   mem_sel_o             0 = data memory, 1 = instruction memory
//   mem_addr_o            word address of the request
//   mem_rvalid_i          read data valid pulse
//   mem_rdata_i           read data
//   tx_data_o             character for the UART transmitter
//   tx_start_o            one-cycle transmit strobe
//   tx_busy_i             transmitter busy (rises the cycle after tx_start_o)
//   dump_running_o        high while a dump or PC print is in progress
// -----------------------------------------------------------------------------
module uart_dump_ctrl #(
    parameter int ADDR_W         = 12,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       uart_data_i,
    input  logic              read_start_set_i,
    input  logic              read_end_set_i,
    input  logic              read_stop_i,
    input  logic              pgm_start_set_i,
    input  logic              pgm_end_set_i,
    input  logic              pgm_stop_i,
    input  logic              pc_print_i,
    input  logic [31:0]       pc_value_i,
    output logic              mem_re_o,
    output logic              mem_sel_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_start_o,
    input  logic              tx_busy_i,
    output logic              dump_running_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_RDREQ, S_RDWAIT, S_CHAR, S_TXGAP, S_SPACE, S_CR, S_LF
    } state_t;

    // Which kind of character was just sent; TXGAP uses it to pick the next step.
    typedef enum logic [1:0] {K_HEX, K_SPACE, K_CR, K_LF} kind_t;

    localparam logic [2:0] LINE_LAST = 3'(WORDS_PER_LINE - 1);

    state_t              state_q, state_d;
    kind_t               kind_q, kind_d;
    logic                sel_q, sel_d;
    logic                pc_mode_q, pc_mode_d;
    logic [ADDR_W-1:0]   rd_start_q, rd_start_d;
    logic [ADDR_W-1:0]   rd_end_q, rd_end_d;
    logic [ADDR_W-1:0]   pg_start_q, pg_start_d;
    logic [ADDR_W-1:0]   pg_end_q, pg_end_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   last_q, last_d;      // effective last word of the running dump
    logic [31:0]         word_q, word_d;
    logic [2:0]          char_cnt_q, char_cnt_d;
    logic [2:0]          line_cnt_q, line_cnt_d;
    logic                dump_running_q;

    logic [ADDR_W-1:0]   addr_w;
    logic                abort;
    logic                at_end;
    logic [3:0]          nibble;
    logic [7:0]          hex_char;
    logic                unused_bits;

    assign addr_w      = uart_data_i[ADDR_W+1:2];
    assign unused_bits = ^{uart_data_i[31:ADDR_W+2], uart_data_i[1:0]};

    // A stop only applies to the memory currently being dumped.
    assign abort  = (state_q != S_IDLE) &&
                    ((read_stop_i && !sel_q) || (pgm_stop_i && sel_q));
    assign at_end = (addr_q == last_q);

    // Word is shifted left after each character, so the top nibble is next.
    assign nibble   = word_q[31:28];
    assign hex_char = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                       : (8'h57 + {4'h0, nibble});

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        sel_d      = sel_q;
        pc_mode_d  = pc_mode_q;
        rd_start_d = rd_start_q;
        rd_end_d   = rd_end_q;
        pg_start_d = pg_start_q;
        pg_end_d   = pg_end_q;
        addr_d     = addr_q;
        last_d     = last_q;
        word_d     = word_q;
        char_cnt_d = char_cnt_q;
        line_cnt_d = line_cnt_q;
        mem_re_o   = 1'b0;
        tx_start_o = 1'b0;
        tx_data_o  = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (read_start_set_i) rd_start_d = addr_w;
                if (read_end_set_i)   rd_end_d   = addr_w;
                if (pgm_start_set_i)  pg_start_d = addr_w;
                if (pgm_end_set_i)    pg_end_d   = addr_w;

                if (pc_print_i) begin
                    word_d     = pc_value_i;
                    pc_mode_d  = 1'b1;
                    char_cnt_d = 3'd0;
                    state_d    = S_CHAR;
                end else if (read_end_set_i) begin
                    sel_d      = 1'b0;
                    pc_mode_d  = 1'b0;
                    addr_d     = rd_start_d;
                    // end below start collapses to a single-word dump
                    last_d     = (rd_end_d < rd_start_d) ? rd_start_d : rd_end_d;
                    line_cnt_d = 3'd0;
                    state_d    = S_RDREQ;
                end else if (pgm_end_set_i) begin
                    sel_d      = 1'b1;
                    pc_mode_d  = 1'b0;
                    addr_d     = pg_start_d;
                    last_d     = (pg_end_d < pg_start_d) ? pg_start_d : pg_end_d;
                    line_cnt_d = 3'd0;
                    state_d    = S_RDREQ;
                end
            end

            S_RDREQ: begin
                mem_re_o = 1'b1;
                state_d  = S_RDWAIT;
            end

            S_RDWAIT: begin
                if (mem_rvalid_i) begin
                    word_d     = mem_rdata_i;
                    char_cnt_d = 3'd0;
                    state_d    = S_CHAR;
                end
            end

            S_CHAR: begin
                if (!tx_busy_i) begin
                    tx_start_o = 1'b1;
                    tx_data_o  = hex_char;
                    word_d     = {word_q[27:0], 4'h0};
                    char_cnt_d = char_cnt_q + 3'd1;
                    kind_d     = K_HEX;
                    state_d    = S_TXGAP;
                end
            end

            S_SPACE: begin
                if (!tx_busy_i) begin
                    tx_start_o = 1'b1;
                    tx_data_o  = 8'h20;
                    kind_d     = K_SPACE;
                    state_d    = S_TXGAP;
                end
            end

            S_CR: begin
                if (!tx_busy_i) begin
                    tx_start_o = 1'b1;
                    tx_data_o  = 8'h0d;
                    kind_d     = K_CR;
                    state_d    = S_TXGAP;
                end
            end

            S_LF: begin
                if (!tx_busy_i) begin
                    tx_start_o = 1'b1;
                    tx_data_o  = 8'h0a;
                    kind_d     = K_LF;
                    state_d    = S_TXGAP;
                end
            end

            // Guard cycle after every strobe: tx_busy is already high here, so
            // the next strobe is at least two cycles later.
            S_TXGAP: begin
                case (kind_q)
                    K_HEX: begin
                        // char_cnt wraps to 0 after the eighth character
                        if (char_cnt_q == 3'd0) state_d = pc_mode_q ? S_CR : S_SPACE;
                        else                    state_d = S_CHAR;
                    end
                    K_SPACE: begin
                        if (at_end || (line_cnt_q == LINE_LAST)) begin
                            state_d = S_CR;
                        end else begin
                            addr_d     = addr_q + ADDR_W'(1);
                            line_cnt_d = line_cnt_q + 3'd1;
                            state_d    = S_RDREQ;
                        end
                    end
                    K_CR: state_d = S_LF;
                    default: begin
                        if (pc_mode_q || at_end) begin
                            state_d = S_IDLE;
                        end else begin
                            addr_d     = addr_q + ADDR_W'(1);
                            line_cnt_d = 3'd0;
                            state_d    = S_RDREQ;
                        end
                    end
                endcase
            end

            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d    = S_IDLE;
            mem_re_o   = 1'b0;
            tx_start_o = 1'b0;
            tx_data_o  = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            kind_q         <= K_HEX;
            sel_q          <= 1'b0;
            pc_mode_q      <= 1'b0;
            rd_start_q     <= '0;
            rd_end_q       <= '0;
            pg_start_q     <= '0;
            pg_end_q       <= '0;
            addr_q         <= '0;
            last_q         <= '0;
            word_q         <= '0;
            char_cnt_q     <= '0;
            line_cnt_q     <= '0;
            dump_running_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            kind_q         <= kind_d;
            sel_q          <= sel_d;
            pc_mode_q      <= pc_mode_d;
            rd_start_q     <= rd_start_d;
            rd_end_q       <= rd_end_d;
            pg_start_q     <= pg_start_d;
            pg_end_q       <= pg_end_d;
            addr_q         <= addr_d;
            last_q         <= last_d;
            word_q         <= word_d;
            char_cnt_q     <= char_cnt_d;
            line_cnt_q     <= line_cnt_d;
            dump_running_q <= (state_d != S_IDLE);
        end
    end

    assign mem_sel_o      = sel_q;
    assign mem_addr_o     = addr_q;
    assign dump_running_o = dump_running_q;

endmodule

// File: tb/tb_uart_dump_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_dump_ctrl
//
// Self-checking bench for uart_dump_ctrl. Memory and UART transmitter are
// behavioural models. The expected character stream and read address list
// come from a reference model built from the printing rules: hex words, a
// space after each word, and CR LF after every WORDS_PER_LINE words or the
// last word. A table of directed vectors is followed by randomized dumps and
// hand-written abort and reset sequences.
// -----------------------------------------------------------------------------
module tb_uart_dump_ctrl;

    localparam int ADDR_W = 12;
    localparam int WPL    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       uart_data;
    logic              read_start_set, read_end_set, read_stop;
    logic              pgm_start_set, pgm_end_set, pgm_stop;
    logic              pc_print;
    logic [31:0]       pc_value;
    logic              mem_re, mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic              dump_running;

    uart_dump_ctrl #(.ADDR_W(ADDR_W), .WORDS_PER_LINE(WPL)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .uart_data_i      (uart_data),
        .read_start_set_i (read_start_set),
        .read_end_set_i   (read_end_set),
        .read_stop_i      (read_stop),
        .pgm_start_set_i  (pgm_start_set),
        .pgm_end_set_i    (pgm_end_set),
        .pgm_stop_i       (pgm_stop),
        .pc_print_i       (pc_print),
        .pc_value_i       (pc_value),
        .mem_re_o         (mem_re),
        .mem_sel_o        (mem_sel),
        .mem_addr_o       (mem_addr),
        .mem_rvalid_i     (mem_rvalid),
        .mem_rdata_i      (mem_rdata),
        .tx_data_o        (tx_data),
        .tx_start_o       (tx_start),
        .tx_busy_i        (tx_busy),
        .dump_running_o   (dump_running)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory contents ----------------
    logic [31:0] salt = 32'h0;
    function automatic logic [31:0] mem_word(logic sel, int addr);
        logic [31:0] a;
        a = 32'(addr);
        if (!sel) return 32'h1111_1111 * a;
        return (a * 32'h0001_0003) ^ salt;
    endfunction

    // ---------------- memory model ----------------
    int          mem_lat = 1;
    logic        pend;
    int          pcnt;
    int          paddr;
    logic        psel;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend       <= 1'b0;
            pcnt       <= 0;
            paddr      <= 0;
            psel       <= 1'b0;
            mem_rvalid <= 1'b0;
            mem_rdata  <= 32'h0;
        end else begin
            mem_rvalid <= 1'b0;
            if (mem_re) begin
                pend  <= 1'b1;
                pcnt  <= mem_lat;
                paddr <= int'(mem_addr);
                psel  <= mem_sel;
            end else if (pend) begin
                if (pcnt == 0) begin
                    mem_rvalid <= 1'b1;
                    mem_rdata  <= mem_word(psel, paddr);
                    pend       <= 1'b0;
                end else begin
                    pcnt <= pcnt - 1;
                end
            end
        end
    end

    // ---------------- UART transmitter model ----------------
    int busy_len = 1;
    int busy_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)              busy_cnt <= 0;
        else if (tx_start)       busy_cnt <= busy_len;
        else if (busy_cnt > 0)   busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    // ---------------- monitor (samples on the falling edge) ----------------
    logic [7:0] txq[$];
    int         re_addr_q[$];
    logic       re_sel_q[$];
    int         busy_viol = 0;
    int         gap_viol  = 0;
    int         last_tx_cyc = -10;
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_start) begin
                txq.push_back(tx_data);
                if (tx_busy) busy_viol++;
                if (cyc - last_tx_cyc < 2) gap_viol++;
                last_tx_cyc = cyc;
            end
            if (mem_re) begin
                re_addr_q.push_back(int'(mem_addr));
                re_sel_q.push_back(mem_sel);
            end
        end
    end

    // ---------------- checking ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(string name, longint act, longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] exp_q[$];
    int         exp_addr[$];

    function automatic void push_hex(logic [31:0] w);
        for (int i = 7; i >= 0; i--) begin
            int nib;
            nib = int'((w >> (4 * i)) & 32'hf);
            exp_q.push_back((nib < 10) ? 8'(48 + nib) : 8'(87 + nib));
        end
    endfunction

    function automatic void build_exp(bit is_pc, bit sel, int s, int e, logic [31:0] pc);
        int last, n;
        exp_q.delete();
        exp_addr.delete();
        if (is_pc) begin
            push_hex(pc);
            exp_q.push_back(8'h0d);
            exp_q.push_back(8'h0a);
            return;
        end
        last = (e < s) ? s : e;
        n = 0;
        for (int a = s; a <= last; a++) begin
            exp_addr.push_back(a);
            push_hex(mem_word(sel, a));
            exp_q.push_back(8'h20);
            n++;
            if ((n % WPL) == 0 || a == last) begin
                exp_q.push_back(8'h0d);
                exp_q.push_back(8'h0a);
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    // which: 0 rs, 1 re, 2 ps, 3 pe, 4 pc, 5 rstop, 6 pstop, 7 pc+re together
    task automatic pulse(int which, logic [31:0] data);
        @(posedge clk); #1;
        uart_data = data;
        case (which)
            0: read_start_set = 1'b1;
            1: read_end_set   = 1'b1;
            2: pgm_start_set  = 1'b1;
            3: pgm_end_set    = 1'b1;
            4: pc_print       = 1'b1;
            5: read_stop      = 1'b1;
            6: pgm_stop       = 1'b1;
            default: begin pc_print = 1'b1; read_end_set = 1'b1; end
        endcase
        @(posedge clk); #1;
        read_start_set = 1'b0; read_end_set = 1'b0; read_stop = 1'b0;
        pgm_start_set  = 1'b0; pgm_end_set  = 1'b0; pgm_stop  = 1'b0;
        pc_print       = 1'b0;
    endtask

    task automatic wait_idle(string name, int limit);
        int k = 0;
        @(negedge clk);
        while (dump_running && k < limit) begin
            @(negedge clk);
            k++;
        end
        check({name, "_timeout"}, dump_running, 0);
    endtask

    task automatic wait_chars(string name, int base, int n, int limit);
        int k = 0;
        while ((txq.size() - base) < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        check({name, "_chars_reached"}, (txq.size() - base) >= n, 1);
    endtask

    typedef struct {
        bit          is_pc;
        bit          sel;
        bit          no_start;
        bit          disturb;
        bit          also_end;
        logic [31:0] start_b;
        logic [31:0] end_b;
        logic [31:0] pc;
        int          busy;
        int          exp_reads;
        int          exp_chars;   // -1: taken from the reference model only
    } vec_t;

    task automatic run_vec(int id, vec_t v);
        int base_tx, base_re, bv0, gv0, mism, first_bad, sel_bad, addr_bad;
        string nm;
        nm = $sformatf("t%0d", id);
        busy_len = v.busy;
        mem_lat  = $urandom_range(0, 3);
        base_tx  = txq.size();
        base_re  = re_addr_q.size();
        bv0      = busy_viol;
        gv0      = gap_viol;
        build_exp(v.is_pc, v.sel, int'(v.start_b[ADDR_W+1:2]), int'(v.end_b[ADDR_W+1:2]), v.pc);

        @(negedge clk);
        check({nm, "_idle_before"}, dump_running, 0);
        if (v.is_pc) begin
            pc_value = v.pc;
            pulse(v.also_end ? 7 : 4, v.end_b);
        end else begin
            if (!v.no_start) pulse(v.sel ? 2 : 0, v.start_b);
            pulse(v.sel ? 3 : 1, v.end_b);
        end
        @(negedge clk);
        check({nm, "_running"}, dump_running, 1);
        if (v.disturb) begin
            // start/end writes during a dump must neither restart nor retarget it
            pulse(0, 32'h40);
            pulse(3, 32'h80);
            pulse(1, 32'h100);
        end
        wait_idle(nm, 20000);
        repeat (6) @(negedge clk);

        if (v.exp_chars >= 0) check({nm, "_nchars_tbl"}, txq.size() - base_tx, v.exp_chars);
        check({nm, "_nchars"}, txq.size() - base_tx, exp_q.size());
        mism = 0; first_bad = -1;
        for (int i = 0; i < exp_q.size() && (base_tx + i) < txq.size(); i++) begin
            if (txq[base_tx + i] !== exp_q[i]) begin
                mism++;
                if (first_bad < 0) first_bad = i;
            end
        end
        check($sformatf("%s_char_mism_first_at_%0d", nm, first_bad), mism, 0);
        check({nm, "_nreads"}, re_addr_q.size() - base_re, v.exp_reads);
        addr_bad = 0; sel_bad = 0;
        for (int i = 0; i < exp_addr.size() && (base_re + i) < re_addr_q.size(); i++) begin
            if (re_addr_q[base_re + i] != exp_addr[i]) addr_bad++;
            if (re_sel_q[base_re + i] !== v.sel) sel_bad++;
        end
        if (!v.is_pc) begin
            check({nm, "_addr_seq"}, addr_bad, 0);
            check({nm, "_mem_sel"}, sel_bad, 0);
        end
        check({nm, "_busy_viol"}, busy_viol - bv0, 0);
        check({nm, "_gap_viol"}, gap_viol - gv0, 0);
        $display("txn %s: pc=%0d sel=%0d start=%0h end=%0h busy=%0d chars=%0d reads=%0d",
                 nm, v.is_pc, v.sel, v.start_b, v.end_b, v.busy,
                 txq.size() - base_tx, re_addr_q.size() - base_re);
    endtask

    vec_t tbl[10];

    initial begin
        int base_tx, base_re, k, cnt_stop, re_stop;
        vec_t rv;

        rst_n = 1'b0;
        uart_data = 32'h0; pc_value = 32'h0;
        read_start_set = 1'b0; read_end_set = 1'b0; read_stop = 1'b0;
        pgm_start_set  = 1'b0; pgm_end_set  = 1'b0; pgm_stop  = 1'b0;
        pc_print = 1'b0;
        salt = $urandom();

        //            pc sel nos dis ae  start          end            pc             busy rd  chars
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10,   32'h1c,        32'h0,         2,  4,  38};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    32'h24,        32'h0,         1,  10, 96};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0,         32'hdeadbeef,  2,  0,  10};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8,    32'h0,         32'h0,         1,  1,  11};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h3ff4, 32'hfffffffc,  32'h0,         1,  3,  29};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10,   32'h1c,        32'h0,         50, 4,  38};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20,   32'h20,        32'h0,         3,  1,  11};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10,   32'h14,        32'h0,         6,  2,  20};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10,   32'h1c,        32'h0,         1,  4,  38};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,    32'h3c,        32'h0123abcd,  2,  0,  10};

        // reset values
        repeat (3) @(negedge clk);
        check("rst_dump_running", dump_running, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_mem_re", mem_re, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_sel", mem_sel, 0);
        check("rst_tx_data", tx_data, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(i, tbl[i]);

        // randomized dumps and prints
        for (int i = 0; i < 8; i++) begin
            int sw, ew;
            sw = $urandom_range(0, 30);
            ew = sw + int'($urandom_range(0, 11)) - 2;
            if (ew < 0) ew = 0;
            rv.is_pc    = ($urandom_range(0, 3) == 0);
            rv.sel      = 1'($urandom_range(0, 1));
            rv.no_start = 1'b0;
            rv.disturb  = 1'b0;
            rv.also_end = 1'b0;
            rv.start_b  = 32'(sw * 4) | 32'($urandom_range(0, 3));
            rv.end_b    = 32'(ew * 4) | 32'($urandom_range(0, 3));
            rv.pc       = $urandom();
            rv.busy     = $urandom_range(1, 6);
            rv.exp_reads = rv.is_pc ? 0 : ((ew < sw) ? 1 : ew - sw + 1);
            rv.exp_chars = -1;
            run_vec(100 + i, rv);
        end

        // abort: wrong-memory stop is ignored, read_stop after 3rd char of word 2
        busy_len = 3;
        mem_lat  = 2;
        build_exp(1'b0, 1'b0, 4, 7, 32'h0);
        base_tx = txq.size();
        base_re = re_addr_q.size();
        pulse(0, 32'h10);
        pulse(1, 32'h1c);
        wait_chars("abort_a", base_tx, 5, 2000);
        pulse(6, 32'h0);
        wait_chars("abort_b", base_tx, 12, 2000);
        pulse(5, 32'h0);
        cnt_stop = txq.size() - base_tx;
        re_stop  = re_addr_q.size() - base_re;
        k = 0;
        @(negedge clk);
        while (dump_running && k < 2) begin @(negedge clk); k++; end
        check("abort_running_low", dump_running, 0);
        repeat (80) @(negedge clk);
        check("abort_chars_at_stop", cnt_stop, 12);
        check("abort_no_more_tx", txq.size() - base_tx, cnt_stop);
        check("abort_no_more_re", re_addr_q.size() - base_re, re_stop);
        k = 0;
        for (int i = 0; i < 12 && (base_tx + i) < txq.size(); i++)
            if (txq[base_tx + i] !== exp_q[i]) k++;
        check("abort_prefix", k, 0);
        $display("txn abort: chars=%0d reads=%0d", txq.size() - base_tx, re_addr_q.size() - base_re);

        // reset in the middle of an instruction-memory dump
        busy_len = 2;
        base_tx = txq.size();
        base_re = re_addr_q.size();
        pulse(2, 32'h44);
        pulse(3, 32'h7c);
        wait_chars("rstmid", base_tx, 5, 2000);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_dump_running", dump_running, 0);
        check("rstmid_tx_start", tx_start, 0);
        check("rstmid_mem_re", mem_re, 0);
        check("rstmid_mem_addr", mem_addr, 0);
        check("rstmid_mem_sel", mem_sel, 0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        cnt_stop = txq.size();
        re_stop  = re_addr_q.size();
        repeat (60) @(negedge clk);
        check("rstmid_no_tx", txq.size(), cnt_stop);
        check("rstmid_no_re", re_addr_q.size(), re_stop);
        check("rstmid_idle", dump_running, 0);
        $display("txn reset_mid: chars_before=%0d", cnt_stop - base_tx);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
